// File: rtl/approx_add_pipe.sv
// Two-stage lower-part-OR approximate adder with per-transaction depth k and an error monitor.
// Latency 2 cycles, 1 result/cycle; valid/ready on both sides, results held stable while stalled.
module approx_add_pipe #(
   parameter int W    = 8,
   parameter int KMAX = 4,
   parameter int ACCW = 24,
   parameter int CNTW = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [W-1:0]                a,
   input  logic [W-1:0]                b,
   input  logic [$clog2(KMAX+1)-1:0]   k,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [W:0]                  sum,
   output logic [W-1:0]                err,
   input  logic                        stat_clr,
   output logic [ACCW-1:0]             err_sum,
   output logic [W-1:0]                err_max,
   output logic [CNTW-1:0]             err_cnt,
   output logic [CNTW-1:0]             smp_cnt
);

   localparam int KW = $clog2(KMAX+1);

   logic            s2_adv;
   logic            s1_adv;
   logic            s1_valid;
   logic [W-1:0]    s1_a;
   logic [W-1:0]    s1_b;
   logic [W-1:0]    s1_lo;
   logic [KW-1:0]   s1_ke;
   logic            s1_cin;

   logic [KW-1:0]   ke_in;
   logic [W-1:0]    mask_in;
   logic [W-1:0]    top_in;

   logic [W-1:0]    mask2;
   logic [W:0]      upper;
   logic [W:0]      approx;
   logic [W:0]      exact;
   logic [W-1:0]    diff_err;

   logic            hs;
   logic [ACCW:0]   err_ext;
   logic [ACCW:0]   acc_nxt;

   assign s2_adv   = !out_valid || out_ready;
   assign s1_adv   = s2_adv || !s1_valid;
   assign in_ready = s1_adv;

   // mask_in covers the approximate LSBs; top_in isolates bit ke-1, whose AND feeds the upper part
   always_comb begin
      ke_in   = (k > KW'(KMAX)) ? KW'(KMAX) : k;
      mask_in = ~({W{1'b1}} << ke_in);
      top_in  = mask_in ^ (mask_in >> 1);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_lo    <= '0;
         s1_ke    <= '0;
         s1_cin   <= 1'b0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a   <= a;
            s1_b   <= b;
            s1_ke  <= ke_in;
            s1_lo  <= (a | b) & mask_in;
            s1_cin <= |(a & b & top_in);
         end
      end
   end

   // Upper operands have their low ke bits cleared, so the carry-in lands exactly at bit ke
   always_comb begin
      mask2    = ~({W{1'b1}} << s1_ke);
      upper    = {1'b0, s1_a & ~mask2} + {1'b0, s1_b & ~mask2}
               + (s1_cin ? {mask2 ^ (mask2 >> 1), 1'b0} : '0);
      approx   = upper | {1'b0, s1_lo};
      exact    = {1'b0, s1_a} + {1'b0, s1_b};
      diff_err = (exact >= approx) ? W'(exact - approx) : W'(approx - exact);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         err       <= '0;
      end else if (s2_adv) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            sum <= approx;
            err <= diff_err;
         end
      end
   end

   assign hs      = out_valid && out_ready;
   assign err_ext = {{(ACCW+1-W){1'b0}}, err};
   assign acc_nxt = {1'b0, err_sum} + err_ext;

   // A clear coinciding with a handshake wins; that result is dropped from the statistics
   always_ff @(posedge clk) begin
      if (!rst_n || stat_clr) begin
         err_sum <= '0;
         err_max <= '0;
         err_cnt <= '0;
         smp_cnt <= '0;
      end else if (hs) begin
         err_sum <= acc_nxt[ACCW] ? '1 : acc_nxt[ACCW-1:0];
         if (err > err_max)
            err_max <= err;
         if ((err != '0) && (err_cnt != '1))
            err_cnt <= err_cnt + CNTW'(1);
         if (smp_cnt != '1)
            smp_cnt <= smp_cnt + CNTW'(1);
      end
   end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Bench for approx_add_pipe: arithmetic reference model plus scoreboard and directed vectors.
module tb_approx_add_pipe;

   localparam int W    = 8;
   localparam int KMAX = 4;
   localparam int ACCW = 10;
   localparam int CNTW = 5;
   localparam int KW   = 3;
   localparam int SUM_MAX = (1 << ACCW) - 1;
   localparam int CNT_MAX = (1 << CNTW) - 1;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            in_valid;
   logic            in_ready;
   logic [W-1:0]    a;
   logic [W-1:0]    b;
   logic [KW-1:0]   k;
   logic            out_valid;
   logic            out_ready;
   logic [W:0]      sum;
   logic [W-1:0]    err;
   logic            stat_clr;
   logic [ACCW-1:0] err_sum;
   logic [W-1:0]    err_max;
   logic [CNTW-1:0] err_cnt;
   logic [CNTW-1:0] smp_cnt;

   always #5 clk = ~clk;

   approx_add_pipe #(.W(W), .KMAX(KMAX), .ACCW(ACCW), .CNTW(CNTW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .k(k), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .err(err), .stat_clr(stat_clr), .err_sum(err_sum),
      .err_max(err_max), .err_cnt(err_cnt), .smp_cnt(smp_cnt)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int acc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: OR the low ke bits, add the rest with the AND of bit ke-1 as carry-in
   function automatic int m_sum(input int av, input int bv, input int kv);
      int ke;
      int lo;
      int cin;
      int up;
      ke  = (kv > KMAX) ? KMAX : kv;
      lo  = 0;
      cin = 0;
      for (int i = 0; i < ke; i++)
         if ((((av >> i) & 1) | ((bv >> i) & 1)) != 0) lo += (1 << i);
      if (ke > 0) cin = (av >> (ke - 1)) & (bv >> (ke - 1)) & 1;
      up = (av >> ke) + (bv >> ke) + cin;
      return up * (1 << ke) + lo;
   endfunction

   function automatic int m_err(input int av, input int bv, input int kv);
      int s;
      int e;
      s = m_sum(av, bv, kv);
      e = av + bv;
      return (e > s) ? e - s : s - e;
   endfunction

   int   q_sum[$];
   int   q_err[$];
   int   ms_sum, ms_max, ms_cnt, ms_smp;
   logic prev_stall = 1'b0;
   logic [W:0]   prev_sum;
   logic [W-1:0] prev_err;

   always @(negedge clk) begin : mon
      int e;
      bit hs;
      hs = 1'b0;
      e  = 0;
      if (rst_n !== 1'b1) begin
         q_sum.delete();
         q_err.delete();
         ms_sum = 0; ms_max = 0; ms_cnt = 0; ms_smp = 0;
         prev_stall = 1'b0;
      end else begin
         chk("stat_err_sum", 64'(err_sum), 64'(ms_sum));
         chk("stat_err_max", 64'(err_max), 64'(ms_max));
         chk("stat_err_cnt", 64'(err_cnt), 64'(ms_cnt));
         chk("stat_smp_cnt", 64'(smp_cnt), 64'(ms_smp));
         if (prev_stall) begin
            chk("hold_valid", 64'(out_valid), 64'(1));
            chk("hold_sum", 64'(sum), 64'(prev_sum));
            chk("hold_err", 64'(err), 64'(prev_err));
         end
         if (out_valid === 1'b1) begin
            if (q_sum.size() == 0) begin
               chk("stale_result", 64'(out_valid), 64'(0));
            end else begin
               chk("sum", 64'(sum), 64'(q_sum[0]));
               chk("err", 64'(err), 64'(q_err[0]));
               if (out_ready === 1'b1) begin
                  e = q_err.pop_front();
                  void'(q_sum.pop_front());
                  hs = 1'b1;
               end
            end
         end
         if (stat_clr === 1'b1) begin
            ms_sum = 0; ms_max = 0; ms_cnt = 0; ms_smp = 0;
         end else if (hs) begin
            ms_sum = (ms_sum + e > SUM_MAX) ? SUM_MAX : ms_sum + e;
            if (e > ms_max) ms_max = e;
            if (e != 0 && ms_cnt < CNT_MAX) ms_cnt++;
            if (ms_smp < CNT_MAX) ms_smp++;
         end
         if (in_valid === 1'b1 && in_ready === 1'b1) begin
            q_sum.push_back(m_sum(int'(a), int'(b), int'(k)));
            q_err.push_back(m_err(int'(a), int'(b), int'(k)));
         end
         prev_stall = (out_valid === 1'b1) && (out_ready !== 1'b1);
         prev_sum   = sum;
         prev_err   = err;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Holds the operands valid until accepted; returns one step after the accepting edge
   task automatic drive(input int av, input int bv, input int kv);
      a = W'(av);
      b = W'(bv);
      k = KW'(kv);
      in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready === 1'b1) begin
            @(posedge clk);
            #1;
            acc++;
            return;
         end
      end
      chk("drive_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic send(input int av, input int bv, input int kv);
      drive(av, bv, kv);
      in_valid = 1'b0;
   endtask

   task automatic send_and_check(input int av, input int bv, input int kv,
                                 input int es, input int ee);
      send(av, bv, kv);
      @(negedge clk);
      chk("lat_cycle1_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
      chk("lat_cycle2_valid", 64'(out_valid), 64'(1));
      chk("lit_sum", 64'(sum), 64'(es));
      chk("lit_err", 64'(err), 64'(ee));
      cyc();
   endtask

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; stat_clr = 1'b0;
      a = '0; b = '0; k = '0;

      chk("model_exact_ff", 64'(m_sum(8'hFF, 8'hFF, 0)), 64'h1FE);
      chk("model_k4_sum", 64'(m_sum(8'h0F, 8'h01, 4)), 64'h00F);
      chk("model_k4_ones", 64'(m_sum(8'hFF, 8'hFF, 4)), 64'h1FF);
      chk("model_clamp_err", 64'(m_err(8'h08, 8'h08, 7)), 64'd8);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_sum", 64'(sum), 64'(0));
      chk("rst_err", 64'(err), 64'(0));
      chk("rst_err_sum", 64'(err_sum), 64'(0));
      chk("rst_smp_cnt", 64'(smp_cnt), 64'(0));
      chk("rst_in_ready", 64'(in_ready), 64'(1));

      send_and_check(8'hFF, 8'hFF, 0, 9'h1FE, 0);
      chk("t1_smp_cnt", 64'(smp_cnt), 64'(1));
      chk("t1_err_cnt", 64'(err_cnt), 64'(0));

      send_and_check(8'h0F, 8'h01, 4, 9'h00F, 1);
      send_and_check(8'hFF, 8'hFF, 4, 9'h1FF, 1);
      chk("t2_err_sum", 64'(err_sum), 64'(2));
      chk("t2_err_max", 64'(err_max), 64'(1));
      chk("t2_err_cnt", 64'(err_cnt), 64'(2));

      send_and_check(8'h08, 8'h08, 7, 9'h018, 8);
      chk("t3_err_max", 64'(err_max), 64'(8));

      // back-to-back transactions, each with its own k
      for (int i = 0; i < 8; i++) drive(8'h3C + 17 * i, 8'h5A + 29 * i, i);
      drive(8'hFF, 8'h01, 3);
      drive(8'h80, 8'h80, 2);
      in_valid = 1'b0;
      repeat (4) cyc();

      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      chk("clr_smp_cnt", 64'(smp_cnt), 64'(0));

      out_ready = 1'b0;
      acc = 0;
      fork
         begin
            repeat (5) @(negedge clk);
            chk("bp_accepts", 64'(acc), 64'(2));
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_first_sum", 64'(sum), 64'h030);
            @(posedge clk);
            #1;
            out_ready = 1'b1;
         end
      join_none
      drive(8'h10, 8'h20, 4);
      drive(8'h17, 8'h29, 4);
      drive(8'h3C, 8'h0F, 4);
      drive(8'hF0, 8'h0F, 4);
      in_valid = 1'b0;
      repeat (6) cyc();
      chk("bp_drained", 64'(out_valid), 64'(0));
      chk("bp_smp_cnt", 64'(smp_cnt), 64'(4));

      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      for (int i = 0; i < 150; i++) drive(8'h08, 8'h08, 4);
      in_valid = 1'b0;
      repeat (4) cyc();
      chk("sat_err_sum", 64'(err_sum), 64'(SUM_MAX));
      chk("sat_err_max", 64'(err_max), 64'(8));
      chk("sat_err_cnt", 64'(err_cnt), 64'(CNT_MAX));
      chk("sat_smp_cnt", 64'(smp_cnt), 64'(CNT_MAX));

      // clear lands on the same edge as the err=3 handshake
      send(8'h03, 8'h03, 4);
      cyc();
      stat_clr = 1'b1;
      cyc();
      stat_clr = 1'b0;
      chk("clrhs_err_sum", 64'(err_sum), 64'(0));
      chk("clrhs_err_max", 64'(err_max), 64'(0));
      chk("clrhs_err_cnt", 64'(err_cnt), 64'(0));
      chk("clrhs_smp_cnt", 64'(smp_cnt), 64'(0));
      send_and_check(8'h02, 8'h02, 2, 9'h006, 2);
      chk("after_clr_err_sum", 64'(err_sum), 64'(2));
      chk("after_clr_smp_cnt", 64'(smp_cnt), 64'(1));

      out_ready = 1'b0;
      drive(8'h11, 8'h22, 1);
      drive(8'h33, 8'h44, 2);
      in_valid = 1'b0;
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      out_ready = 1'b1;
      chk("mrst_out_valid", 64'(out_valid), 64'(0));
      chk("mrst_err_sum", 64'(err_sum), 64'(0));
      chk("mrst_smp_cnt", 64'(smp_cnt), 64'(0));
      chk("mrst_in_ready", 64'(in_ready), 64'(1));
      for (int i = 0; i < 6; i++) begin
         cyc();
         chk("mrst_no_stale", 64'(out_valid), 64'(0));
      end

      chk("queue_empty", 64'(q_sum.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
- Parametrised, pipelined lower-part-OR approximate adder (LOA). Next generation of the fixed 8-bit approximate adders in the library.
- Adds configurable width, a per-transaction runtime approximation depth k with an exact mode, and valid/ready flow control.
- Includes a built-in error monitor that computes each result's deviation from the exact sum and accumulates statistics.
- Sits between operand producers and accuracy-characterisation or datapath consumers.

Parameters:
- W, 8, operand width in bits (W >= 2).
- KMAX, 4, maximum approximate LSB count (1 <= KMAX <= W-1).
- ACCW, 24, width of the error-sum accumulator.
- CNTW, 16, width of the sample and error-event counters.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operand transaction valid
- in_ready  out  1  block can accept an operand transaction
- a  in  W  operand A
- b  in  W  operand B
- k  in  $clog2(KMAX+1)  approximate LSB count; 0 = exact
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sum  out  W+1  approximate sum
- err  out  W  |exact - approximate| for the current result
- stat_clr  in  1  clear statistics (single-cycle pulse)
- err_sum  out  ACCW  saturating sum of err over consumed results
- err_max  out  W  maximum err over consumed results
- err_cnt  out  CNTW  saturating count of consumed results with err != 0
- smp_cnt  out  CNTW  saturating count of consumed results

Behaviour:
- Reset: one clock is synchronous and active-low, with rst_n low at a clk edge. Reset clears both pipeline valids, sum, err and all statistics to 0. in_ready is 1 from the first cycle after reset. Reset mid-operation discards in-flight results; none are counted.
- Arithmetic, with ke = min(k, KMAX) sampled with the operands:
  - For i < ke: sum[i] = a[i] | b[i].
  - Carry into the upper part: cin = (ke > 0) ? (a[ke-1] & b[ke-1]) : 0.
  - sum[W:ke] = a[W-1:ke] + b[W-1:ke] + cin, full carry out into sum[W].
  - ke = 0 gives the exact a + b.
- Error: exact = a + b (W+1 bits); err = |exact - sum|. err < 2^ke always, so W bits suffice.
- Pipeline, two stages:
  - S1 registers a, b and ke; it also computes the lower OR field and cin.
  - S2 registers sum, err and out_valid.
  - Latency is 2 cycles from in_valid & in_ready to out_valid with no stall.
  - Throughput is 1 result per cycle.
- Handshake:
  - S2 advances when !out_valid | out_ready.
  - S1 advances when S2 advances or S1 is empty.
  - in_ready = !s1_valid | s2_advance. This is combinational from out_ready; there is no combinational path from in_valid to in_ready.
  - A transfer occurs on valid & ready. sum and err are held stable while out_valid & !out_ready.
  - in_valid may drop without a transfer.
- Statistics update on output handshake (out_valid & out_ready):
  - err_sum += err, saturating at 2^ACCW-1.
  - err_max = max(err_max, err).
  - err_cnt increments if err != 0; smp_cnt increments. Both saturate at 2^CNTW-1.
  - Statistics are registered and visible the cycle after the handshake.
- stat_clr zeroes all four statistics. When it coincides with a handshake, the clear wins and that result is not counted. stat_clr does not affect the pipeline.
- Boundaries:
  - k > KMAX is clamped to KMAX.
  - The all-ones operands case must produce carry out in sum[W].
  - Back-to-back transactions with differing k must each use their own k.

Test Plan:
- W=8, KMAX=4, out_ready=1. Send k=0, a=0xFF, b=0xFF -> 2 cycles later sum=0x1FE, err=0. Then smp_cnt=1, err_cnt=0.
- k=4, a=0x0F, b=0x01 -> sum=0x00F, err=1. k=4, a=0xFF, b=0xFF -> sum=0x1FF, err=1. After both, err_sum=2, err_max=1, err_cnt=2.
- k=7 (clamp to 4), a=0x08, b=0x08 -> sum=0x018, exact 0x010, err=8. err_max becomes 8.
- Backpressure: stream 4 transactions with k=4 and hold out_ready=0 for 5 cycles.
  - in_ready drops after 2 accepts.
  - sum and err stay stable on the first result.
  - Releasing out_ready delivers all 4 results in order with no loss or duplication. smp_cnt=4.
- Issue stat_clr in the same cycle as an output handshake with err=3 -> all statistics read 0 next cycle. The next handshake with err=2 gives err_sum=2, smp_cnt=1.
- Assert rst_n=0 while 2 results are in flight -> out_valid=0, statistics 0, and in_ready=1 the cycle after rst_n returns high. No stale result emerges.
